// File: rtl/reaction_timer.sv
// reaction_timer: control stage of the reaction game.
// Latches the generator's value as a millisecond delay, waits it out, lights
// the target LED, then measures the player's response in milliseconds. A press
// before the LED is flagged as a false start.
// Optional feature: define REACTION_BEST_EN to add the best_ms output, which
// tracks the fastest completed round since reset.
module reaction_timer #(
    parameter int unsigned MS_DIV = 50000,
    parameter int unsigned MAX_MS = 9999
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stop,
    input  logic [13:0] random,
    input  logic        rnd_ready,
    output logic        led,
    output logic [13:0] rt_ms,
    output logic        rt_valid,
    output logic        too_early,
`ifdef REACTION_BEST_EN
    output logic [13:0] best_ms,
`endif
    output logic        busy
);

    localparam int unsigned   PW         = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(MS_DIV - 1);
    localparam logic [13:0]   MAX_CNT    = 14'(MAX_MS);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RND,
        DELAY,
        ARMED,
        DONE,
        EARLY
    } state_t;

    state_t        state_q;
    logic [PW-1:0] presc_q;
    logic [13:0]   cnt_q;
    logic          led_q;
    logic          rt_valid_q;
    logic          too_early_q;
    logic          busy_q;
    logic [13:0]   rt_ms_q;
`ifdef REACTION_BEST_EN
    logic [13:0]   best_q;
`endif

    logic          presc_wrap;
    logic          last_ms;
    logic [PW-1:0] presc_d;
    logic [13:0]   load_d;
    logic [13:0]   cnt_dec_d;
    logic [13:0]   cnt_inc_d;
    logic [13:0]   rt_d;

    // Prescaler wrap, counter next values and the result captured on stop
    always_comb begin
        presc_wrap = (presc_q == PRESC_LAST);
        presc_d    = presc_wrap ? '0 : presc_q + 1'b1;
        // A zero delay from the generator is run as one millisecond
        load_d     = (random == '0) ? 14'd1 : random;
        cnt_dec_d  = cnt_q - 14'd1;
        last_ms    = presc_wrap && (cnt_q <= 14'd1);
        cnt_inc_d  = (cnt_q >= MAX_CNT) ? MAX_CNT : cnt_q + 14'd1;
        // A stop landing on a wrap edge completes that millisecond
        rt_d       = presc_wrap ? cnt_inc_d : cnt_q;
    end

    // Round sequencing with registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            cnt_q       <= '0;
            led_q       <= 1'b0;
            rt_valid_q  <= 1'b0;
            too_early_q <= 1'b0;
            busy_q      <= 1'b0;
            rt_ms_q     <= '0;
`ifdef REACTION_BEST_EN
            best_q      <= MAX_CNT;
`endif
        end else begin
            case (state_q)
                IDLE, DONE, EARLY: begin
                    if (start) begin
                        state_q     <= WAIT_RND;
                        busy_q      <= 1'b1;
                        rt_valid_q  <= 1'b0;
                        too_early_q <= 1'b0;
                    end
                end

                WAIT_RND: begin
                    if (stop) begin
                        state_q     <= EARLY;
                        busy_q      <= 1'b0;
                        too_early_q <= 1'b1;
                    end else if (rnd_ready) begin
                        state_q <= DELAY;
                        cnt_q   <= load_d;
                        presc_q <= '0;
                    end
                end

                DELAY: begin
                    if (stop) begin
                        // A press on the final decrement edge still counts as early
                        state_q     <= EARLY;
                        busy_q      <= 1'b0;
                        too_early_q <= 1'b1;
                    end else if (last_ms) begin
                        state_q <= ARMED;
                        led_q   <= 1'b1;
                        cnt_q   <= '0;
                        presc_q <= '0;
                    end else begin
                        presc_q <= presc_d;
                        if (presc_wrap) begin
                            cnt_q <= cnt_dec_d;
                        end
                    end
                end

                ARMED: begin
                    if (stop) begin
                        state_q    <= DONE;
                        led_q      <= 1'b0;
                        busy_q     <= 1'b0;
                        rt_valid_q <= 1'b1;
                        rt_ms_q    <= rt_d;
`ifdef REACTION_BEST_EN
                        if (rt_d < best_q) begin
                            best_q <= rt_d;
                        end
`endif
                    end else begin
                        presc_q <= presc_d;
                        if (presc_wrap) begin
                            cnt_q <= cnt_inc_d;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                    led_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign led       = led_q;
    assign rt_ms     = rt_ms_q;
    assign rt_valid  = rt_valid_q;
    assign too_early = too_early_q;
    assign busy      = busy_q;
`ifdef REACTION_BEST_EN
    assign best_ms   = best_q;
`endif

endmodule

// File: tb/tb_reaction_timer.sv
// Self-checking bench for reaction_timer (MS_DIV=4, MAX_MS=9999).
// Expected timing comes from edge arithmetic: the LED rises 1 + D*MS_DIV edges
// after the start edge, and the result is floor(cycles lit / MS_DIV), capped.
module tb_reaction_timer;

    localparam int MS_DIV = 4;
    localparam int MAX_MS = 9999;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [13:0] random = '0;
    logic        rnd_ready = 1'b0;
    logic        led;
    logic [13:0] rt_ms;
    logic        rt_valid;
    logic        too_early;
    logic        busy;
`ifdef REACTION_BEST_EN
    logic [13:0] best_ms;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_rt   = 0;
    int exp_best = MAX_MS;

    reaction_timer #(
        .MS_DIV(MS_DIV),
        .MAX_MS(MAX_MS)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .stop     (stop),
        .random   (random),
        .rnd_ready(rnd_ready),
        .led      (led),
        .rt_ms    (rt_ms),
        .rt_valid (rt_valid),
        .too_early(too_early),
`ifdef REACTION_BEST_EN
        .best_ms  (best_ms),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1500000;
        $display("FAIL watchdog: time %0t cycle %0d, run did not complete", $time, cyc);
        $fatal(1, "watchdog expired");
    end

    function automatic int expected_rt(input int lit_cycles);
        int v;
        v = lit_cycles / MS_DIV;
        return (v > MAX_MS) ? MAX_MS : v;
    endfunction

    // Stimulus only: pulse start with the generator ready; returns at the
    // negedge after the start edge with that edge index and the LED-rise edge.
    task automatic start_round(input int d, output int n_edge, output int rise);
        random    = 14'(d);
        rnd_ready = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        n_edge = cyc;
        rise   = cyc + 1 + ((d == 0) ? 1 : d) * MS_DIV;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (led !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_led_busy: led=%b busy=%b expected 0 0", led, busy);
        end
        n_checks++;
        if (rt_ms !== 14'd0 || rt_valid !== 1'b0 || too_early !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_result: rt_ms=%0d rt_valid=%b too_early=%b expected 0 0 0",
                     rt_ms, rt_valid, too_early);
        end
`ifdef REACTION_BEST_EN
        n_checks++;
        if (best_ms !== 14'(MAX_MS)) begin
            n_fail++;
            $display("FAIL reset_best: got %0d expected %0d", best_ms, MAX_MS);
        end
`endif
        reset_n = 1'b1;
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        @(negedge clk);
        n_checks++;
        if (too_early !== 1'b0 || busy !== 1'b0 || led !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_stop_ignored: too_early=%b busy=%b led=%b expected 0 0 0",
                     too_early, busy, led);
        end
    endtask

    task automatic test_normal_round;
        int n, rise, bad;
        bad = 0;
        start_round(1000, n, rise);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_busy: got %b expected 1", busy);
        end
        while (cyc < rise) begin
            if (led !== 1'b0) bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL normal_led_early: %0d cycles lit before edge %0d, expected 0", bad, rise);
        end
        n_checks++;
        if (led !== 1'b1 || cyc - n != 4001) begin
            n_fail++;
            $display("FAIL normal_led_rise: led=%b at %0d edges after start, expected 1 at 4001",
                     led, cyc - n);
        end
        for (int k = 1; k <= 20; k++) begin
            stop = (k == 20);
            @(negedge clk);
        end
        stop = 1'b0;
        exp_rt = expected_rt(20);
        n_checks++;
        if (rt_ms !== 14'(exp_rt) || rt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL normal_result: rt_ms=%0d rt_valid=%b expected %0d 1", rt_ms, rt_valid, exp_rt);
        end
        n_checks++;
        if (led !== 1'b0 || busy !== 1'b0 || too_early !== 1'b0) begin
            n_fail++;
            $display("FAIL normal_done_flags: led=%b busy=%b too_early=%b expected 0 0 0",
                     led, busy, too_early);
        end
    endtask

    task automatic test_false_start;
        int n, rise, bad;
        bad = 0;
        start_round(1000, n, rise);
        while (cyc < n + 100) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        n_checks++;
        if (too_early !== 1'b1 || busy !== 1'b0 || rt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL early_flags: too_early=%b busy=%b rt_valid=%b expected 1 0 0",
                     too_early, busy, rt_valid);
        end
        n_checks++;
        if (rt_ms !== 14'(exp_rt)) begin
            n_fail++;
            $display("FAIL early_rt_kept: got %0d expected %0d", rt_ms, exp_rt);
        end
        while (cyc < rise + 10) begin
            if (led !== 1'b0) bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL early_led_stays_off: lit for %0d cycles, expected 0", bad);
        end
        rnd_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (too_early !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_clears_early: too_early=%b busy=%b expected 0 1", too_early, busy);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        n_checks++;
        if (too_early !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_rnd_stop: too_early=%b busy=%b expected 1 0", too_early, busy);
        end
    endtask

    task automatic test_not_ready;
        int bad, rise, react;
        bad = 0;
        rnd_ready = 1'b0;
        random = 14'($urandom_range(1000, 5000));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) begin
            if (busy !== 1'b1 || led !== 1'b0) bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL not_ready_hold: %0d cycles left waiting, expected 0", bad);
        end
        random = 14'd1200;
        rnd_ready = 1'b1;
        rise = cyc + 1 + 1200 * MS_DIV;
        bad = 0;
        while (cyc < rise) begin
            if (led !== 1'b0) bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad != 0 || led !== 1'b1) begin
            n_fail++;
            $display("FAIL not_ready_delay: early lit=%0d led=%b at edge %0d, expected 0 1", bad, led, rise);
        end
        react = $urandom_range(1, 60);
        for (int k = 1; k <= react; k++) begin
            stop = (k == react);
            @(negedge clk);
        end
        stop = 1'b0;
        exp_rt = expected_rt(react);
        n_checks++;
        if (rt_ms !== 14'(exp_rt) || rt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL not_ready_result: rt_ms=%0d rt_valid=%b expected %0d 1", rt_ms, rt_valid, exp_rt);
        end
    endtask

    task automatic test_final_decrement;
        int n, rise;
        start_round(2, n, rise);
        while (cyc < rise - 1) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        n_checks++;
        if (too_early !== 1'b1 || led !== 1'b0 || rt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_on_final_decrement: too_early=%b led=%b rt_valid=%b expected 1 0 0",
                     too_early, led, rt_valid);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (led !== 1'b0 || rt_ms !== 14'(exp_rt)) begin
            n_fail++;
            $display("FAIL final_decrement_after: led=%b rt_ms=%0d expected 0 %0d", led, rt_ms, exp_rt);
        end
    endtask

    // Short random rounds; a start pulse lands in DELAY and again in ARMED,
    // and a stray stop follows in DONE, none of which may disturb the round.
    task automatic test_random_rounds;
        for (int r = 0; r < 6; r++) begin
            int n, rise, bad, d, react;
            d = $urandom_range(0, 6);
            react = $urandom_range(1, 40);
            bad = 0;
            start_round(d, n, rise);
            while (cyc < rise) begin
                if (led !== 1'b0) bad++;
                start = (cyc == n + 1);
                @(negedge clk);
            end
            start = 1'b0;
            n_checks++;
            if (bad != 0 || led !== 1'b1) begin
                n_fail++;
                $display("FAIL rand_led_rise: d=%0d early lit=%0d led=%b expected 0 1", d, bad, led);
            end
            for (int k = 1; k <= react; k++) begin
                start = (k == 1);
                stop  = (k == react);
                @(negedge clk);
            end
            start = 1'b0;
            stop  = 1'b0;
            exp_rt = expected_rt(react);
            n_checks++;
            if (rt_ms !== 14'(exp_rt) || rt_valid !== 1'b1 || led !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_result: react=%0d rt_ms=%0d rt_valid=%b led=%b expected %0d 1 0",
                         react, rt_ms, rt_valid, led, exp_rt);
            end
            stop = 1'b1;
            @(negedge clk);
            stop = 1'b0;
            @(negedge clk);
            n_checks++;
            if (rt_valid !== 1'b1 || too_early !== 1'b0 || rt_ms !== 14'(exp_rt)) begin
                n_fail++;
                $display("FAIL done_stop_ignored: rt_valid=%b too_early=%b rt_ms=%0d expected 1 0 %0d",
                         rt_valid, too_early, rt_ms, exp_rt);
            end
        end
    endtask

    task automatic test_saturation;
        int n, rise;
        start_round($urandom_range(1, 4), n, rise);
        while (cyc < rise) @(negedge clk);
        for (int k = 1; k <= 50000; k++) begin
            stop = (k == 50000);
            @(negedge clk);
        end
        stop = 1'b0;
        exp_rt = expected_rt(50000);
        n_checks++;
        if (rt_ms !== 14'(exp_rt) || rt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL saturation: rt_ms=%0d rt_valid=%b expected %0d 1", rt_ms, rt_valid, exp_rt);
        end
    endtask

    task automatic test_reset_armed;
        int n, rise;
        start_round($urandom_range(1, 4), n, rise);
        while (cyc < rise + 3) @(negedge clk);
        n_checks++;
        if (led !== 1'b1) begin
            n_fail++;
            $display("FAIL armed_before_reset: led=%b expected 1", led);
        end
        #1;
        reset_n = 1'b0;
        #1;
        exp_rt = 0;
        exp_best = MAX_MS;
        n_checks++;
        if (led !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_led: led=%b busy=%b expected 0 0 before any edge", led, busy);
        end
        n_checks++;
        if (rt_ms !== 14'd0 || rt_valid !== 1'b0 || too_early !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_result: rt_ms=%0d rt_valid=%b too_early=%b expected 0 0 0",
                     rt_ms, rt_valid, too_early);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || led !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: busy=%b led=%b expected 0 0", busy, led);
        end
    endtask

`ifdef REACTION_BEST_EN
    task automatic test_best;
        int ms_list [3] = '{7, 3, 5};
        for (int r = 0; r < 3; r++) begin
            int n, rise, react;
            react = ms_list[r] * MS_DIV + $urandom_range(0, MS_DIV - 1);
            start_round($urandom_range(1, 3), n, rise);
            while (cyc < rise) @(negedge clk);
            for (int k = 1; k <= react; k++) begin
                stop = (k == react);
                @(negedge clk);
            end
            stop = 1'b0;
            exp_rt = expected_rt(react);
            if (exp_rt < exp_best) exp_best = exp_rt;
            n_checks++;
            if (best_ms !== 14'(exp_best) || rt_ms !== 14'(exp_rt)) begin
                n_fail++;
                $display("FAIL best_round%0d: best_ms=%0d rt_ms=%0d expected %0d %0d",
                         r, best_ms, rt_ms, exp_best, exp_rt);
            end
        end
        begin
            int n, rise;
            start_round(3, n, rise);
            repeat (2) @(negedge clk);
            stop = 1'b1;
            @(negedge clk);
            stop = 1'b0;
            n_checks++;
            if (best_ms !== 14'(exp_best) || too_early !== 1'b1) begin
                n_fail++;
                $display("FAIL best_after_early: best_ms=%0d too_early=%b expected %0d 1",
                         best_ms, too_early, exp_best);
            end
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset;
        test_normal_round;
        test_false_start;
        test_not_ready;
        test_final_decrement;
        test_random_rounds;
        test_saturation;
        test_reset_armed;
`ifdef REACTION_BEST_EN
        test_best;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
